// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-cycle WORDS*16-bit add/subtract built around one shared
// 16-bit carry-lookahead adder. One word goes through per cycle, LS word first,
// and the carry between words is held in a register.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   start_valid/start_ready    request handshake (ready only in IDLE)
//   op_sub, a_in, b_in         operation and operands, sampled at accept
//   res_valid/res_ready        result handshake (valid only in DONE)
//   result, carry_out, overflow  W-bit result, carry out of MSB (sub: 1 = no
//                              borrow), two's-complement overflow

// 4-bit lookahead slice: local sum plus group generate/propagate.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       gg,
  output logic       pg
);
  logic [3:0] g, p, c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign s  = p ^ c;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;
endmodule

// 16-bit adder: four cla4 slices with a second-level lookahead for slice carries.
module cla_16 (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [3:0] gg, pg;
  logic [4:0] cg;

  for (genvar i = 0; i < 4; i++) begin : g_slice
    cla4 u_cla4 (
      .a   (in1[4*i +: 4]),
      .b   (in2[4*i +: 4]),
      .cin (cg[i]),
      .s   (sum[4*i +: 4]),
      .gg  (gg[i]),
      .pg  (pg[i])
    );
  end

  assign cg[0] = cin;
  assign cg[1] = gg[0] | (pg[0] & cin);
  assign cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
  assign cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
               | (pg[2] & pg[1] & pg[0] & cin);
  assign cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
               | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
  assign cout  = cg[4];
endmodule

module wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic                op_sub,
  input  logic [16*WORDS-1:0] a_in,
  input  logic [16*WORDS-1:0] b_in,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [16*WORDS-1:0] result,
  output logic                carry_out,
  output logic                overflow
);
  localparam int W = 16 * WORDS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [WORDS-1:0][15:0]   a_r, b_r, res_w;  // b_r holds B' (B or ~B)
  logic [WORDS-1:0]         wsel;             // one-hot word index, bit 0 = word 0
  logic                     creg;
  logic [15:0]              in1, in2, sum;
  logic                     cout;

  // One-hot word select keeps the datapath free of any counter adder.
  always_comb begin
    in1 = '0;
    in2 = '0;
    for (int i = 0; i < WORDS; i++) begin
      in1 = in1 | (a_r[i] & {16{wsel[i]}});
      in2 = in2 | (b_r[i] & {16{wsel[i]}});
    end
  end

  cla_16 u_cla (
    .in1  (in1),
    .in2  (in2),
    .cin  (creg),
    .sum  (sum),
    .cout (cout)
  );

  assign result = res_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wsel        <= WORDS'(1);
      creg        <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      res_w       <= '0;
      carry_out   <= 1'b0;
      overflow    <= 1'b0;
      res_valid   <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start_valid) begin
          a_r         <= a_in;
          b_r         <= op_sub ? ~b_in : b_in;
          creg        <= op_sub;  // +1 completes the two's-complement of B
          wsel        <= WORDS'(1);
          start_ready <= 1'b0;
          state       <= RUN;
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++)
            if (wsel[i]) res_w[i] <= sum;
          creg <= cout;
          if (wsel[WORDS-1]) begin
            carry_out <= cout;
            overflow  <= (a_r[WORDS-1][15] == b_r[WORDS-1][15]) &&
                         (sum[15] != a_r[WORDS-1][15]);
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            wsel <= wsel << 1;
          end
        end
        DONE: if (res_ready) begin
          res_valid   <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_w;
  assign unused_w = ^W;
endmodule

// File: tb/tb_wide_add_seq.sv
module tb_wide_add_seq;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0, op_sub = 1'b0, res_ready = 1'b0;
  logic [63:0] a_in = '0, b_in = '0;
  logic        start_ready, res_valid, carry_out, overflow;
  logic [63:0] result;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op_sub(op_sub), .a_in(a_in), .b_in(b_in), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  typedef struct {
    logic        sub;
    logic [63:0] a, b, res;
    logic        c, ov;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: wide integer arithmetic on the whole operands.
  task automatic model(input logic sub, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic c, output logic ov);
    logic [64:0]        u;
    logic signed [65:0] s;
    if (sub) begin
      res = a - b;
      c   = (a >= b);
      s   = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
    end else begin
      u   = {1'b0, a} + {1'b0, b};
      res = u[63:0];
      c   = u[64];
      s   = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
    end
    ov = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -66'sh0_8000_0000_0000_0000);
  endtask

  // Run one operation; hold res_ready low for `hold` cycles while in DONE.
  task automatic run_op(input logic sub, input logic [63:0] a, input logic [63:0] b,
                        input int hold, output logic [63:0] r, output logic c,
                        output logic ov, output int lat);
    logic [63:0] r0;
    logic        c0, ov0;
    @(negedge clk);
    start_valid = 1'b1; op_sub = sub; a_in = a; b_in = b;
    @(posedge clk); #1;
    start_valid = 1'b0;
    // inputs changed after accept must not disturb the operation
    op_sub = ~sub; a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid) begin
      n_chk++; n_fail++;
      $display("FAIL res_valid_timeout: got 0 expected 1 within 20 cycles");
    end
    r = result; c = carry_out; ov = overflow;
    r0 = result; c0 = carry_out; ov0 = overflow;
    for (int k = 0; k < hold; k++) begin
      start_valid = (k == 1);
      a_in = {$urandom, $urandom};
      @(posedge clk); #1;
      start_valid = 1'b0;
      chk("bp_valid", 64'(res_valid), 64'd1);
      chk("bp_start_ready", 64'(start_ready), 64'd0);
      chk("bp_result", result, r0);
      chk("bp_flags", {62'd0, carry_out, overflow}, {62'd0, c0, ov0});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  logic [63:0] r, er;
  logic        c, ov, ec, eov;
  int          lat;
  vec_t        tbl[7];

  initial begin
    tbl[0] = '{0, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 0, 0};
    tbl[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1, 0};
    tbl[2] = '{1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0};
    tbl[3] = '{0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 0, 1};
    tbl[4] = '{1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1};
    tbl[5] = '{1, 64'h5, 64'h5, 64'h0, 1, 0};
    tbl[6] = '{0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1, 1};

    #12;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {62'd0, carry_out, overflow}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].sub, tbl[i].a, tbl[i].b, 0, r, c, ov, lat);
      chk($sformatf("vec%0d_result", i), r, tbl[i].res);
      chk($sformatf("vec%0d_carry", i), 64'(c), 64'(tbl[i].c));
      chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'(tbl[i].ov));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(WORDS));
      chk($sformatf("vec%0d_idle_ready", i), 64'(start_ready), 64'd1);
      chk($sformatf("vec%0d_valid_drop", i), 64'(res_valid), 64'd0);
      chk($sformatf("vec%0d_retained", i), result, tbl[i].res);
    end

    // backpressure: 5 cycles with res_ready low, start pulse in DONE ignored
    run_op(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5, r, c, ov, lat);
    model(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, er, ec, eov);
    chk("bp_final_result", r, er);
    chk("bp_no_accept", 64'(start_ready), 64'd1);

    // random back-to-back operations
    for (int n = 0; n < 40; n++) begin
      logic        s;
      logic [63:0] a, b;
      s = 1'($urandom);
      a = {$urandom, $urandom};
      b = (n % 5 == 0) ? ~a : {$urandom, $urandom};
      model(s, a, b, er, ec, eov);
      run_op(s, a, b, n % 3, r, c, ov, lat);
      chk("rnd_result", r, er);
      chk("rnd_flags", {62'd0, c, ov}, {62'd0, ec, eov});
      chk("rnd_latency", 64'(lat), 64'(WORDS));
    end

    // reset while RUN is on word 2
    @(negedge clk);
    start_valid = 1'b1; op_sub = 1'b0; a_in = 64'hFFFF_FFFF_FFFF_FFFF; b_in = 64'h1;
    @(posedge clk); #1; start_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_flags", {62'd0, carry_out, overflow}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(start_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_no_valid", 64'(res_valid), 64'd0);
    end
    model(1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, er, ec, eov);
    run_op(1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, r, c, ov, lat);
    chk("post_rst_result", r, er);
    chk("post_rst_flags", {62'd0, c, ov}, {62'd0, ec, eov});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
